// File: rtl/frame_fifo_write.sv
// frame_fifo_write: drains the user write FIFO into memory as burst writes for one requested frame.
module frame_fifo_write #(
  parameter int MEM_DATA_BITS = 32,
  parameter int ADDR_BITS     = 23,
  parameter int BUSRT_BITS    = 10,
  parameter int BURST_SIZE    = 128
) (
  input  logic                  mem_clk,
  input  logic                  rst,
  output logic                  wr_burst_req,
  output logic [BUSRT_BITS-1:0] wr_burst_len,
  output logic [ADDR_BITS-1:0]  wr_burst_addr,
  input  logic                  wr_burst_data_req,
  input  logic                  wr_burst_finish,
  input  logic                  write_req,
  output logic                  write_req_ack,
  output logic                  write_finish,
  input  logic [ADDR_BITS-1:0]  write_addr_0,
  input  logic [ADDR_BITS-1:0]  write_addr_1,
  input  logic [ADDR_BITS-1:0]  write_addr_2,
  input  logic [ADDR_BITS-1:0]  write_addr_3,
  input  logic [1:0]            write_addr_index,
  input  logic [ADDR_BITS-1:0]  write_len,
  output logic                  fifo_aclr,
  input  logic [15:0]           rdusedw
);
  if (BURST_SIZE >= (1 << BUSRT_BITS) || BURST_SIZE < 1 || MEM_DATA_BITS < 1) begin : g_bad_params
    $error("frame_fifo_write: BURST_SIZE must fit in BUSRT_BITS");
  end

  localparam logic [ADDR_BITS-1:0]  BURST_A = ADDR_BITS'(BURST_SIZE);
  localparam logic [BUSRT_BITS-1:0] BURST_B = BUSRT_BITS'(BURST_SIZE);

  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_CHECK_FIFO, S_WRITE_BURST, S_WRITE_BURST_END, S_END
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            req_sync_q;
  logic [ADDR_BITS-1:0]  len_s0_q, len_s1_q;
  logic [1:0]            idx_s0_q, idx_s1_q;
  logic [ADDR_BITS-1:0]  cnt_q, cnt_d, len_latch_q, len_latch_d, addr_q, addr_d;
  logic [BUSRT_BITS-1:0] blen_q, blen_d;
  logic                  breq_q, breq_d, ack_q, ack_d, aclr_q, aclr_d;
  logic                  req;
  logic [ADDR_BITS-1:0]  rem, addr_sel;
  logic [BUSRT_BITS-1:0] blen;

  assign req      = req_sync_q[2];
  assign rem      = len_latch_q - cnt_q;
  assign blen     = (rem < BURST_A) ? BUSRT_BITS'(rem) : BURST_B;
  assign addr_sel = idx_s1_q == 2'd0 ? write_addr_0 :
                    idx_s1_q == 2'd1 ? write_addr_1 :
                    idx_s1_q == 2'd2 ? write_addr_2 : write_addr_3;

  assign wr_burst_req  = breq_q;
  assign wr_burst_len  = blen_q;
  assign wr_burst_addr = addr_q;
  assign write_req_ack = ack_q;
  assign fifo_aclr     = aclr_q;
  assign write_finish  = state_q == S_END;

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_sync_q  <= '0;
      len_s0_q    <= '0;
      len_s1_q    <= '0;
      idx_s0_q    <= '0;
      idx_s1_q    <= '0;
      cnt_q       <= '0;
      len_latch_q <= '0;
      addr_q      <= '0;
      blen_q      <= '0;
      breq_q      <= 1'b0;
      ack_q       <= 1'b0;
      aclr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_sync_q  <= {req_sync_q[1:0], write_req};
      len_s0_q    <= write_len;
      len_s1_q    <= len_s0_q;
      idx_s0_q    <= write_addr_index;
      idx_s1_q    <= idx_s0_q;
      cnt_q       <= cnt_d;
      len_latch_q <= len_latch_d;
      addr_q      <= addr_d;
      blen_q      <= blen_d;
      breq_q      <= breq_d;
      ack_q       <= ack_d;
      aclr_q      <= aclr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_latch_d = len_latch_q;
    addr_d      = addr_q;
    blen_d      = blen_q;
    breq_d      = breq_q;
    ack_d       = ack_q;
    aclr_d      = aclr_q;
    case (state_q)
      S_IDLE: begin
        ack_d   = 1'b0;
        state_d = req ? S_ACK : S_IDLE;
      end
      S_ACK: begin
        cnt_d       = '0;
        ack_d       = req;
        aclr_d      = req;
        addr_d      = req ? addr_sel : addr_q;
        len_latch_d = req ? len_s1_q : len_latch_q;
        state_d     = req ? S_ACK : S_CHECK_FIFO;
      end
      S_CHECK_FIFO: begin
        if (req) state_d = S_ACK;
        else if (cnt_q >= len_latch_q) state_d = S_END;
        else if (32'(rdusedw) >= 32'(blen)) begin
          blen_d  = blen;
          breq_d  = 1'b1;
          state_d = S_WRITE_BURST;
        end
      end
      S_WRITE_BURST: begin
        // A pending write_req waits until the in-flight burst has finished.
        if (wr_burst_data_req) breq_d = 1'b0;
        if (wr_burst_finish) begin
          cnt_d   = cnt_q + ADDR_BITS'(blen_q);
          addr_d  = addr_q + ADDR_BITS'(blen_q);
          breq_d  = 1'b0;
          state_d = S_WRITE_BURST_END;
        end
      end
      S_WRITE_BURST_END:
        state_d = req ? S_ACK : (cnt_q < len_latch_q) ? S_CHECK_FIFO : S_END;
      S_END: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_frame_fifo_write.sv
// tb_frame_fifo_write: scoreboard bench; expected bursts are queued per frame and checked as the DUT issues them.
module tb_frame_fifo_write;
  logic        mem_clk = 1'b0;
  logic        rst;
  logic        wr_burst_req;
  logic [9:0]  wr_burst_len;
  logic [22:0] wr_burst_addr;
  logic        wr_burst_data_req;
  logic        wr_burst_finish;
  logic        write_req;
  logic        write_req_ack;
  logic        write_finish;
  logic [22:0] write_addr_0, write_addr_1, write_addr_2, write_addr_3;
  logic [1:0]  write_addr_index;
  logic [22:0] write_len;
  logic        fifo_aclr;
  logic [15:0] rdusedw;

  typedef struct {
    logic [22:0] a;
    logic [9:0]  l;
  } burst_t;

  burst_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 mem_clk = ~mem_clk;

  frame_fifo_write dut (
    .mem_clk(mem_clk), .rst(rst),
    .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
    .wr_burst_data_req(wr_burst_data_req), .wr_burst_finish(wr_burst_finish),
    .write_req(write_req), .write_req_ack(write_req_ack), .write_finish(write_finish),
    .write_addr_0(write_addr_0), .write_addr_1(write_addr_1),
    .write_addr_2(write_addr_2), .write_addr_3(write_addr_3),
    .write_addr_index(write_addr_index), .write_len(write_len),
    .fifo_aclr(fifo_aclr), .rdusedw(rdusedw)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge mem_clk);
  endtask

  task automatic push(input logic [22:0] a, input logic [9:0] l);
    burst_t b;
    b.a = a;
    b.l = l;
    exp_q.push_back(b);
  endtask

  task automatic wait_ack(input logic v);
    int t = 0;
    while (write_req_ack !== v && t < 50) begin
      tick();
      t++;
    end
  endtask

  task automatic wait_req();
    int t = 0;
    while (wr_burst_req !== 1'b1 && t < 100) begin
      tick();
      t++;
    end
    check("burst_req_seen", 32'(wr_burst_req), 32'd1);
  endtask

  task automatic handshake(input logic [1:0] idx, input logic [22:0] len);
    write_addr_index = idx;
    write_len = len;
    repeat (3) tick();
    write_req = 1'b1;
    wait_ack(1'b1);
    check("ack_rise", 32'(write_req_ack), 32'd1);
    check("aclr_with_ack", 32'(fifo_aclr), 32'd1);
    write_req = 1'b0;
    wait_ack(1'b0);
    check("ack_fall", 32'(write_req_ack), 32'd0);
    check("aclr_fall", 32'(fifo_aclr), 32'd0);
  endtask

  // Controller model: checks the burst against the scoreboard, then streams data and pulses finish.
  task automatic serve_burst();
    int n;
    burst_t e;
    if (exp_q.size() == 0) check("burst_unexpected", 32'd1, 32'd0);
    else begin
      e = exp_q.pop_front();
      check("burst_addr", 32'(wr_burst_addr), 32'(e.a));
      check("burst_len", 32'(wr_burst_len), 32'(e.l));
    end
    n = int'(wr_burst_len);
    tick();
    wr_burst_data_req = 1'b1;
    tick();
    check("req_drop", 32'(wr_burst_req), 32'd0);
    for (int i = 1; i < n; i++) tick();
    wr_burst_data_req = 1'b0;
    wr_burst_finish = 1'b1;
    tick();
    wr_burst_finish = 1'b0;
  endtask

  task automatic run_frame(input logic [22:0] final_addr);
    int fin = 0;
    int t = 0;
    int extra = 0;
    while (fin == 0 && t < 4000) begin
      if (wr_burst_req === 1'b1) serve_burst();
      else begin
        if (write_finish === 1'b1) fin = 1;
        tick();
        t++;
      end
    end
    check("finish_seen", 32'(fin), 32'd1);
    repeat (6) begin
      if (write_finish !== 1'b0 || wr_burst_req !== 1'b0) extra++;
      tick();
    end
    check("finish_single", 32'(extra), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_addr", 32'(wr_burst_addr), 32'(final_addr));
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    wr_burst_data_req = 1'b0;
    wr_burst_finish = 1'b0;
    write_req = 1'b0;
    write_addr_0 = 23'h2000;
    write_addr_1 = 23'h1000;
    write_addr_2 = 23'h4000;
    write_addr_3 = 23'h20000;
    write_addr_index = 2'd0;
    write_len = '0;
    rdusedw = '0;
    repeat (2) tick();
    check("rst_req", 32'(wr_burst_req), 32'd0);
    check("rst_ack", 32'(write_req_ack), 32'd0);
    check("rst_aclr", 32'(fifo_aclr), 32'd0);
    check("rst_finish", 32'(write_finish), 32'd0);
    check("rst_addr", 32'(wr_burst_addr), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // two full bursts
    rdusedw = 16'd200;
    handshake(2'd1, 23'd256);
    push(23'h1000, 10'd128);
    push(23'h1080, 10'd128);
    run_frame(23'h1100);

    // partial final burst
    rdusedw = 16'd256;
    handshake(2'd3, 23'd300);
    push(23'h20000, 10'd128);
    push(23'h20080, 10'd128);
    push(23'h20100, 10'd44);
    run_frame(23'h2012C);

    // FIFO starvation one word short
    rdusedw = 16'd127;
    handshake(2'd1, 23'd128);
    push(23'h1000, 10'd128);
    repeat (10) begin
      check("starve_noreq", 32'(wr_burst_req), 32'd0);
      tick();
    end
    rdusedw = 16'd128;
    tick();
    check("starve_release", 32'(wr_burst_req), 32'd1);
    run_frame(23'h1080);

    // new request during a burst restarts the frame after it
    rdusedw = 16'd200;
    handshake(2'd0, 23'd256);
    push(23'h2000, 10'd128);
    wait_req();
    write_addr_index = 2'd2;
    write_req = 1'b1;
    serve_burst();
    wait_ack(1'b1);
    check("abort_ack", 32'(write_req_ack), 32'd1);
    write_req = 1'b0;
    wait_ack(1'b0);
    push(23'h4000, 10'd128);
    push(23'h4080, 10'd128);
    run_frame(23'h4100);

    // asynchronous reset mid-burst
    handshake(2'd1, 23'd256);
    push(23'h1000, 10'd128);
    wait_req();
    void'(exp_q.pop_front());
    tick();
    wr_burst_data_req = 1'b1;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_req", 32'(wr_burst_req), 32'd0);
    check("arst_ack", 32'(write_req_ack), 32'd0);
    check("arst_aclr", 32'(fifo_aclr), 32'd0);
    check("arst_len", 32'(wr_burst_len), 32'd0);
    check("arst_addr", 32'(wr_burst_addr), 32'd0);
    tick();
    wr_burst_data_req = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    repeat (20) begin
      check("post_rst_idle", 32'({wr_burst_req, write_req_ack, write_finish}), 32'd0);
      tick();
    end

    // zero-length frame
    handshake(2'd0, 23'd0);
    run_frame(23'h2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
